// File: rtl/expression_result_unpacker_if.sv
// Handshake bundle between a packed-result producer, the unpacker and the
// per-field consumer. The master side drives words in and takes beats out;
// the slave side is the unpacker itself.
interface expression_result_unpacker_if #(
    parameter int EXT_W   = 8,
    parameter int COUNT_W = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [89:0]        in_y;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [EXT_W-1:0]   out_field;
    logic [4:0]         out_index;
    logic [2:0]         out_width;
    logic               out_signed;
    logic               out_last;
    logic               done;
    logic [COUNT_W-1:0] words_done;

    modport master (
        output in_valid, in_y, flush, out_ready,
        input  in_ready, out_valid, out_field, out_index, out_width,
               out_signed, out_last, done, words_done
    );

    modport slave (
        input  in_valid, in_y, flush, out_ready,
        output in_ready, out_valid, out_field, out_index, out_width,
               out_signed, out_last, done, words_done
    );
endinterface

// File: rtl/expression_result_unpacker.sv
// Sequential unpacker for the 90-bit expression result vector. A word is
// latched into a hold register and its 18 fields are emitted MSB-first, one
// per accepted beat, each extended to EXT_W bits by its signedness.
// Field i has width 4 + (i mod 3) and is signed when (i mod 6) >= 3, so the
// field properties are tracked with a mod-3 counter plus a half-group bit
// instead of dividing the index.
module expression_result_unpacker #(
    parameter int EXT_W   = 8,
    parameter int COUNT_W = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    expression_result_unpacker_if.slave   bus
);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [89:0]        hold_q, hold_d;
    logic [4:0]         idx_q, idx_d;
    logic [1:0]         sub_q, sub_d;     // index mod 3: selects width 4/5/6
    logic               half_q, half_d;   // second half of a six-field group: signed
    logic               done_q, done_d;
    logic [COUNT_W-1:0] words_q, words_d;

    logic               emitting;
    logic [2:0]         cur_width;
    logic [5:0]         raw;
    logic               sign_fill;
    logic [EXT_W-1:0]   ext;

    assign emitting  = (state_q == EMIT);
    assign cur_width = 3'd4 + {1'b0, sub_q};
    // The current field always starts at the top of the hold register, so
    // its sign bit is hold_q[89] whatever its width.
    assign sign_fill = half_q & hold_q[89];

    // Right-align the current field from the top of the hold register
    always_comb begin
        raw = 6'd0;
        case (sub_q)
            2'd0:    raw = {2'b00, hold_q[89:86]};
            2'd1:    raw = {1'b0,  hold_q[89:85]};
            default: raw = hold_q[89:84];
        endcase
    end

    // Per-bit extension: field bits below the width, fill bits above it
    generate
        for (genvar gi = 0; gi < EXT_W; gi++) begin : g_ext
            if (gi < 6) begin : g_low
                assign ext[gi] = (3'(gi) < cur_width) ? raw[gi] : sign_fill;
            end else begin : g_high
                assign ext[gi] = sign_fill;
            end
        end
    endgenerate

    // Next-state and datapath update; flush overrides every handshake
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        half_d  = half_q;
        done_d  = 1'b0;
        words_d = words_q;
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        hold_d  = bus.in_y;
                        idx_d   = 5'd0;
                        sub_d   = 2'd0;
                        half_d  = 1'b0;
                        state_d = EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (idx_q == 5'd17) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            if (words_q != {COUNT_W{1'b1}}) begin
                                words_d = words_q + 1'b1;
                            end
                        end else begin
                            case (sub_q)
                                2'd0:    hold_d = hold_q << 4;
                                2'd1:    hold_d = hold_q << 5;
                                default: hold_d = hold_q << 6;
                            endcase
                            idx_d = idx_q + 5'd1;
                            if (sub_q == 2'd2) begin
                                sub_d  = 2'd0;
                                half_d = ~half_q;
                            end else begin
                                sub_d = sub_q + 2'd1;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            idx_q   <= '0;
            sub_q   <= '0;
            half_q  <= 1'b0;
            done_q  <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            idx_q   <= idx_d;
            sub_q   <= sub_d;
            half_q  <= half_d;
            done_q  <= done_d;
            words_q <= words_d;
        end
    end

    // Beat outputs are forced to zero outside EMIT so reset and idle read 0
    assign bus.in_ready   = (state_q == IDLE);
    assign bus.out_valid  = emitting;
    assign bus.out_field  = emitting ? ext : '0;
    assign bus.out_index  = emitting ? idx_q : 5'd0;
    assign bus.out_width  = emitting ? cur_width : 3'd0;
    assign bus.out_signed = emitting & half_q;
    assign bus.out_last   = emitting & (idx_q == 5'd17);
    assign bus.done       = done_q;
    assign bus.words_done = words_q;

endmodule

// File: tb/tb_expression_result_unpacker.sv
// Scoreboard bench for the expression result unpacker: every word driven
// pushes its 18 expected beats, the negedge monitor pops and compares them
// and also tracks done timing, the saturating word count and stall stability.
module tb_expression_result_unpacker;

    localparam int EXT_W   = 8;
    localparam int COUNT_W = 2;

    typedef struct {
        logic [7:0] field;
        int         index;
        int         width;
        logic       sgn;
    } beat_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    expression_result_unpacker_if #(.EXT_W(EXT_W), .COUNT_W(COUNT_W)) bus ();

    expression_result_unpacker #(.EXT_W(EXT_W), .COUNT_W(COUNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    beat_t exp_q[$];
    int    tests_run    = 0;
    int    tests_failed = 0;
    int    cyc          = 0;
    int    exp_done     = 0;
    bit    pending      = 0;
    int    words_model  = 0;
    int    accepts      = 0;
    bit    bp_mode      = 0;
    int    bp_k         = 0;
    logic [3:0] bp_pat  = 4'b1001;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Expected beats of one word, walking the field map by cumulative width
    task automatic push_word(input logic [89:0] y);
        int pos;
        pos = 90;
        for (int i = 0; i < 18; i++) begin
            int w, raw, val;
            logic [89:0] t;
            beat_t b;
            w   = 4 + (i % 3);
            pos = pos - w;
            t   = y >> pos;
            raw = int'(t[5:0]) & ((1 << w) - 1);
            val = raw;
            b.sgn = ((i % 6) >= 3);
            if (b.sgn && ((raw >> (w - 1)) & 1) == 1) val = raw - (1 << w);
            b.field = 8'(val);
            b.index = i;
            b.width = w;
            exp_q.push_back(b);
        end
    endtask

    function automatic logic [89:0] pack(input int vals[18]);
        logic [89:0] y;
        int pos;
        y   = '0;
        pos = 90;
        for (int i = 0; i < 18; i++) begin
            int w;
            w   = 4 + (i % 3);
            pos = pos - w;
            y   = y | (90'(vals[i] & ((1 << w) - 1)) << pos);
        end
        return y;
    endfunction

    // out_ready: held at 1, or cycled 1,0,0,1 during the backpressure test
    always @(posedge clk) begin
        #1;
        if (bp_mode) begin
            bus.out_ready = bp_pat[bp_k % 4];
            bp_k++;
        end else begin
            bus.out_ready = 1'b1;
        end
    end

    // Monitor: scoreboard pops, done/count timing, stall stability
    logic       stalled_prev = 1'b0;
    logic [7:0] prev_field;
    logic [4:0] prev_index;
    always @(negedge clk) begin
        beat_t b;
        if (!rst_n) begin
            stalled_prev = 1'b0;
        end else begin
            check("in_ready_excl", 32'(bus.in_ready), 32'(!bus.out_valid));
            if (stalled_prev) begin
                check("stall_valid", 32'(bus.out_valid), 32'd1);
                check("stall_field", 32'(bus.out_field), 32'(prev_field));
                check("stall_index", 32'(bus.out_index), 32'(prev_index));
            end
            if (bus.out_valid && bus.out_ready && !bus.flush) begin
                if (exp_q.size() == 0) begin
                    check("beat_unexpected", 32'(bus.out_index), 32'hFFFF_FFFF);
                end else begin
                    b = exp_q.pop_front();
                    check("field",  32'(bus.out_field),  32'(b.field));
                    check("index",  32'(bus.out_index),  32'(b.index));
                    check("width",  32'(bus.out_width),  32'(b.width));
                    check("signed", 32'(bus.out_signed), 32'(b.sgn));
                    check("last",   32'(bus.out_last),   32'(b.index == 17));
                end
            end
            if (pending && cyc == exp_done) begin
                words_model = (words_model == 3) ? 3 : words_model + 1;
                check("done_pulse", 32'(bus.done), 32'd1);
                check("words_done", 32'(bus.words_done), 32'(words_model));
                check("in_ready_at_done", 32'(bus.in_ready), 32'd1);
                $display("[TB] word done cycle %0d words_done %0d", cyc, bus.words_done);
                pending = 1'b0;
            end else begin
                check("done_quiet", 32'(bus.done), 32'd0);
            end
            if (bus.in_valid && bus.in_ready && !bus.flush) begin
                pending  = 1'b1;
                exp_done = cyc + 19;
                accepts++;
            end
            if (bus.out_valid && !bus.out_ready && !bus.flush) exp_done++;
            stalled_prev = bus.out_valid && !bus.out_ready && !bus.flush;
            prev_field   = bus.out_field;
            prev_index   = bus.out_index;
        end
    end

    task automatic send_word(input logic [89:0] y);
        int n;
        push_word(y);
        @(posedge clk); #1;
        bus.in_y     = y;
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 100);
        if (n >= 100) check("in_accept_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pending) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) check("idle_timeout", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
    endtask

    task automatic wait_index(input int idx);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.out_valid && bus.out_ready && int'(bus.out_index) == idx) && n < 200);
        if (n >= 200) check("index_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int vals[18];
        int n;
        bus.in_valid  = 1'b0;
        bus.in_y      = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_in_ready",  32'(bus.in_ready),   32'd1);
        check("rst_out_valid", 32'(bus.out_valid),  32'd0);
        check("rst_field",     32'(bus.out_field),  32'd0);
        check("rst_index",     32'(bus.out_index),  32'd0);
        check("rst_width",     32'(bus.out_width),  32'd0);
        check("rst_signed",    32'(bus.out_signed), 32'd0);
        check("rst_last",      32'(bus.out_last),   32'd0);
        check("rst_done",      32'(bus.done),       32'd0);
        check("rst_words",     32'(bus.words_done), 32'd0);
        #11 rst_n = 1'b1;

        // All-ones word
        send_word({90{1'b1}});
        wait_idle();

        // Sign boundaries
        for (int i = 0; i < 18; i++) vals[i] = 0;
        vals[0] = 8; vals[3] = 8; vals[4] = 15; vals[5] = 32;
        send_word(pack(vals));
        wait_idle();

        // Backpressure with field i = i
        for (int i = 0; i < 18; i++) vals[i] = i;
        bp_k    = 0;
        bp_mode = 1'b1;
        send_word(pack(vals));
        wait_idle();
        bp_mode = 1'b0;

        // Flush after index 7 is accepted
        for (int i = 0; i < 18; i++) vals[i] = 17 - i;
        send_word(pack(vals));
        wait_index(7);
        @(posedge clk); #1;
        bus.flush = 1'b1;
        exp_q.delete();
        pending = 1'b0;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        check("flush_in_ready",  32'(bus.in_ready),   32'd1);
        check("flush_out_valid", 32'(bus.out_valid),  32'd0);
        check("flush_done",      32'(bus.done),       32'd0);
        check("flush_words",     32'(bus.words_done), 32'(words_model));
        for (int i = 0; i < 18; i++) vals[i] = (i * 7 + 3);
        send_word(pack(vals));
        wait_idle();

        // Asynchronous reset mid-word at index 10
        for (int i = 0; i < 18; i++) vals[i] = 63 - i;
        send_word(pack(vals));
        wait_index(10);
        #2 rst_n = 1'b0;
        #1;
        exp_q.delete();
        pending     = 1'b0;
        words_model = 0;
        check("arst_out_valid", 32'(bus.out_valid),  32'd0);
        check("arst_field",     32'(bus.out_field),  32'd0);
        check("arst_index",     32'(bus.out_index),  32'd0);
        check("arst_width",     32'(bus.out_width),  32'd0);
        check("arst_last",      32'(bus.out_last),   32'd0);
        check("arst_words",     32'(bus.words_done), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(negedge clk);
        check("arst_in_ready", 32'(bus.in_ready),   32'd1);
        check("arst_words2",   32'(bus.words_done), 32'd0);

        // Saturation: five back-to-back words with in_valid held high
        for (int w = 0; w < 5; w++) push_word({18{w[4:0]}});
        @(posedge clk); #1;
        accepts      = 0;
        bus.in_y     = {18{5'd0}};
        bus.in_valid = 1'b1;
        n = 0;
        while (accepts < 5 && n < 300) begin
            @(negedge clk);
            n++;
            if (bus.in_ready) begin
                @(posedge clk); #1;
                bus.in_y = {18{5'(accepts)}};
            end
        end
        if (n >= 300) check("sat_accept_timeout", 32'(accepts), 32'd5);
        bus.in_valid = 1'b0;
        wait_idle();
        check("sat_words_final", 32'(bus.words_done), 32'd3);

        #20;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
